// File: rtl/rmt_phv_pkg.sv
// Shared PHV/value layout constants for the RMT stage blocks.
// Optional feature macro used by phv_key_insert: PHV_INSERT_COND_EN.
package rmt_phv_pkg;

    // Container widths and counts
    localparam int W_2B    = 16;
    localparam int W_4B    = 32;
    localparam int W_6B    = 48;
    localparam int N_2B    = 8;
    localparam int N_4B    = 8;
    localparam int N_6B    = 8;
    localparam int N_OPS   = 5;
    localparam int OP_W    = 20;
    localparam int META_W  = 256;

    // PHV layout, LSB first: metadata, ops, 2B, 4B, 6B containers
    localparam int OFF_META  = 0;
    localparam int OFF_OPS   = OFF_META + META_W;
    localparam int OFF_2B    = OFF_OPS + N_OPS * OP_W;
    localparam int OFF_4B    = OFF_2B + N_2B * W_2B;
    localparam int OFF_6B    = OFF_4B + N_4B * W_4B;
    localparam int PHV_LEN_C = OFF_6B + N_6B * W_6B;

    // VLAN id location inside the metadata
    localparam int VLAN_W   = 12;
    localparam int VLAN_LSB = 129;
    localparam int VLAN_MSB = VLAN_LSB + VLAN_W - 1;

    // Value vector layout, LSB first: condition bits, 2B B/A, 4B B/A, 6B B/A
    localparam int VAL_COND_W = 5;
    localparam int VAL_2B_B   = VAL_COND_W;
    localparam int VAL_2B_A   = VAL_2B_B + W_2B;
    localparam int VAL_4B_B   = VAL_2B_A + W_2B;
    localparam int VAL_4B_A   = VAL_4B_B + W_4B;
    localparam int VAL_6B_B   = VAL_4B_A + W_4B;
    localparam int VAL_6B_A   = VAL_6B_B + W_6B;
    localparam int VAL_LEN_C  = VAL_6B_A + W_6B;

    // Insert-offset entry: six nibbles of {en, idx[2:0]}
    localparam int INS_OFF_W = 24;
    localparam int ENT_6B_A  = 20;
    localparam int ENT_6B_B  = 16;
    localparam int ENT_4B_A  = 12;
    localparam int ENT_4B_B  = 8;
    localparam int ENT_2B_A  = 4;
    localparam int ENT_2B_B  = 0;

    typedef struct packed {
        logic       en;
        logic [2:0] idx;
    } ins_slot_t;

    // Bit offset of container idx within a container group starting at base
    function automatic int cont_off(input int base, input int width, input logic [2:0] idx);
        return base + width * int'(idx);
    endfunction

endpackage

// File: rtl/ins_off_ram.sv
// Insert-offset table: 2^AW x DW, synchronous write, synchronous read-first.
// Kept as its own module so a vendor block RAM can replace it.
module ins_off_ram #(
    parameter int DW = 24,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    // Storage is not reset; it powers up all-zero (every slot disabled)
    logic [DW-1:0] mem_q [2**AW];
    logic [DW-1:0] rd_data_d;
    logic [DW-1:0] rd_data_q;

    // Array write; the read below sees the pre-write contents (read-first)
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Read address decode
    always_comb begin
        rd_data_d = mem_q[rd_addr];
    end

    // Registered read data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/phv_key_insert.sv
// Stage write-back: inserts up to two 6B, two 4B and two 2B values into PHV
// containers at per-tenant offsets (table indexed by vlan_id[7:4]), 2-cycle
// latency, no backpressure.
// Optional feature macro: PHV_INSERT_COND_EN (gate writes on val_in[4-STAGE]).
module phv_key_insert
    import rmt_phv_pkg::*;
#(
    parameter int STAGE              = 0,
    parameter int PHV_LEN            = PHV_LEN_C,
    parameter int VAL_LEN            = VAL_LEN_C,
    parameter int INS_OFF            = INS_OFF_W,
    parameter int AXIL_WIDTH         = 32,
    parameter int INS_OFF_ADDR_WIDTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [PHV_LEN-1:0]            phv_in,
    input  logic                          phv_valid_in,
    input  logic [VAL_LEN-1:0]            val_in,
    input  logic                          val_valid_in,
    input  logic [AXIL_WIDTH-1:0]         ins_off_entry_in,
    input  logic                          ins_off_entry_in_valid,
    input  logic [INS_OFF_ADDR_WIDTH-1:0] ins_off_entry_addr,
    output logic [PHV_LEN-1:0]            phv_out,
    output logic                          phv_valid_out,
    output logic [15:0]                   mismatch_cnt
);

    localparam int COND_BIT = 4 - STAGE;

    // Handshake: phv_valid_in/val_valid_in qualify their data for one cycle
    // only; there is no ready. A write happens when both are high together.
    // phv_valid_out is a one-cycle qualifier for phv_out, which otherwise holds.

    logic [VLAN_W-1:0]             vlan_id;
    logic [INS_OFF-1:0]            entry;

    logic [PHV_LEN-1:0]            phv_s1_d, phv_s1_q;
    logic [VAL_LEN-1:0]            val_s1_d, val_s1_q;
    logic                          vld_s1_d, vld_s1_q;
    logic                          wr_s1_d, wr_s1_q;
    logic [15:0]                   mis_cnt_d, mis_cnt_q;

    logic [PHV_LEN-1:0]            phv_mod;
    logic [PHV_LEN-1:0]            phv_out_d, phv_out_q;
    logic                          vld_out_d, vld_out_q;

    ins_slot_t                     s6_a, s6_b, s4_a, s4_b, s2_a, s2_b;

    logic                          unused_bits;

    assign vlan_id = phv_in[VLAN_MSB:VLAN_LSB];

    // Table read is issued in cycle 0 from the incoming PHV's tenant bits
    ins_off_ram #(
        .DW (INS_OFF),
        .AW (INS_OFF_ADDR_WIDTH)
    ) u_ins_off_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (ins_off_entry_in_valid),
        .wr_addr (ins_off_entry_addr),
        .wr_data (ins_off_entry_in[INS_OFF-1:0]),
        .rd_addr (vlan_id[7:4]),
        .rd_data (entry)
    );

    // Cycle 0: capture PHV/value, pair-valid, and count unpaired valids
    always_comb begin
        phv_s1_d = phv_in;
        val_s1_d = val_in;
        vld_s1_d = phv_valid_in;
`ifdef PHV_INSERT_COND_EN
        wr_s1_d  = phv_valid_in & val_valid_in & val_in[COND_BIT];
`else
        wr_s1_d  = phv_valid_in & val_valid_in;
`endif
        mis_cnt_d = mis_cnt_q;
        if ((phv_valid_in ^ val_valid_in) && (mis_cnt_q != 16'hFFFF)) begin
            mis_cnt_d = mis_cnt_q + 16'd1;
        end
    end

    // Cycle 1: apply enabled slots; A before B so B wins on a shared index
    always_comb begin
        s6_a = ins_slot_t'(entry[ENT_6B_A +: 4]);
        s6_b = ins_slot_t'(entry[ENT_6B_B +: 4]);
        s4_a = ins_slot_t'(entry[ENT_4B_A +: 4]);
        s4_b = ins_slot_t'(entry[ENT_4B_B +: 4]);
        s2_a = ins_slot_t'(entry[ENT_2B_A +: 4]);
        s2_b = ins_slot_t'(entry[ENT_2B_B +: 4]);
        phv_mod = phv_s1_q;
        if (wr_s1_q) begin
            if (s6_a.en) phv_mod[cont_off(OFF_6B, W_6B, s6_a.idx) +: W_6B] = val_s1_q[VAL_6B_A +: W_6B];
            if (s6_b.en) phv_mod[cont_off(OFF_6B, W_6B, s6_b.idx) +: W_6B] = val_s1_q[VAL_6B_B +: W_6B];
            if (s4_a.en) phv_mod[cont_off(OFF_4B, W_4B, s4_a.idx) +: W_4B] = val_s1_q[VAL_4B_A +: W_4B];
            if (s4_b.en) phv_mod[cont_off(OFF_4B, W_4B, s4_b.idx) +: W_4B] = val_s1_q[VAL_4B_B +: W_4B];
            if (s2_a.en) phv_mod[cont_off(OFF_2B, W_2B, s2_a.idx) +: W_2B] = val_s1_q[VAL_2B_A +: W_2B];
            if (s2_b.en) phv_mod[cont_off(OFF_2B, W_2B, s2_b.idx) +: W_2B] = val_s1_q[VAL_2B_B +: W_2B];
        end
    end

    // Output stage: load on a valid PHV, otherwise hold the last value
    always_comb begin
        vld_out_d = vld_s1_q;
        phv_out_d = phv_out_q;
        if (vld_s1_q) begin
            phv_out_d = phv_mod;
        end
    end

    // Pipeline registers; reset discards in-flight PHVs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phv_s1_q  <= '0;
            val_s1_q  <= '0;
            vld_s1_q  <= 1'b0;
            wr_s1_q   <= 1'b0;
            mis_cnt_q <= '0;
            phv_out_q <= '0;
            vld_out_q <= 1'b0;
        end else begin
            phv_s1_q  <= phv_s1_d;
            val_s1_q  <= val_s1_d;
            vld_s1_q  <= vld_s1_d;
            wr_s1_q   <= wr_s1_d;
            mis_cnt_q <= mis_cnt_d;
            phv_out_q <= phv_out_d;
            vld_out_q <= vld_out_d;
        end
    end

    assign phv_out       = phv_out_q;
    assign phv_valid_out = vld_out_q;
    assign mismatch_cnt  = mis_cnt_q;

    // Config bits above the entry width, condition bits and the rest of
    // vlan_id have no function in this datapath
    assign unused_bits = ^{ins_off_entry_in[AXIL_WIDTH-1:INS_OFF],
                           val_s1_q[VAL_COND_W-1:0], val_in[COND_BIT],
                           vlan_id[VLAN_W-1:8], vlan_id[3:0]};

endmodule

// File: doc/phv_key_insert.md
Name: phv_key_insert

Overview:
- Write-back counterpart of the stage key extractor.
- Takes a PHV plus the 197-bit value vector produced by the stage's match/action path. Writes up to two 6B, two 4B and two 2B values back into PHV containers at per-tenant insert offsets, then forwards the modified PHV to the next stage.
- The offset table is indexed by VLAN ID bits [7:4] and is written over the same 32-bit config bus style as the extractor.

Parameters:
- STAGE, 0, stage index 0..4; selects condition bit val_in[4-STAGE].
- PHV_LEN, 48*8+32*8+16*8+5*20+256 (1124), PHV width.
- VAL_LEN, 48*2+32*2+16*2+5 (197), value vector width, same packing as extractor key.
- INS_OFF, 24, insert entry width: 6 slots x {en, idx[2:0]}.
- AXIL_WIDTH, 32, config data width.
- INS_OFF_ADDR_WIDTH, 4, table depth 16.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- phv_in  in  PHV_LEN  incoming PHV
- phv_valid_in  in  1  PHV qualifier
- val_in  in  VAL_LEN  values to insert
- val_valid_in  in  1  value qualifier
- ins_off_entry_in  in  AXIL_WIDTH  config data; [23:0] used
- ins_off_entry_in_valid  in  1  config write strobe
- ins_off_entry_addr  in  INS_OFF_ADDR_WIDTH  config address
- phv_out  out  PHV_LEN  modified PHV
- phv_valid_out  out  1  output qualifier
- mismatch_cnt  out  16  saturating count of unpaired phv/val valids

Interface rule: reset rst_n, asynchronous, active-low; clock clk.

Behaviour:
- Reset values: phv_out=0, phv_valid_out=0, mismatch_cnt=0, pipeline valids=0. Table contents are not reset; they power up as all-zero, i.e. every slot disabled.
- PHV layout, MSB first:
  - 6B containers 7..0 at PHV_LEN-1 downward.
  - 4B containers 7..0.
  - 2B containers 7..0.
  - 5x20b op fields.
  - 256b metadata; vlan_id=phv[140:129].
- Value layout, MSB first: 6B A, 6B B, 4B A, 4B B, 2B A, 2B B, 5 condition bits [4:0].
- Entry layout: [23:20] 6B A, [19:16] 6B B, [15:12] 4B A, [11:8] 4B B, [7:4] 2B A, [3:0] 2B B. Bit 3 of each nibble is the enable, bits 2:0 the container index.
- Table: 16x24 register array.
  - Write port: synchronous write on ins_off_entry_in_valid.
  - Read port: synchronous read, addr = phv_in[136:133] (vlan_id[7:4]) sampled every cycle.
  - Same-address write and read in one cycle returns the old entry (read-first).
- Pipeline: fixed latency 2 cycles, no backpressure.
  - Cycle 0: phv_in, val_in and pair-valid are registered; table read issued.
  - Cycle 1: entry available. Modified containers are computed combinationally and registered into phv_out. phv_valid_out=1 in cycle 2 exactly when phv_valid_in was 1 in cycle 0.
- Insert rule: for each enabled slot, container[idx] is replaced by the slot value. All non-container fields (ops, metadata) pass unchanged. Disabled slots leave their container untouched.
- Collision: A and B of the same width target the same index -> B value wins.
- Unpaired valids:
  - phv_valid_in=1 with val_valid_in=0: PHV forwarded unmodified, mismatch_cnt+1.
  - val_valid_in=1 with phv_valid_in=0: value dropped, mismatch_cnt+1.
  - mismatch_cnt saturates at 16'hFFFF.
- When phv_valid_out=0, phv_out holds its last value.
- Back-to-back PHVs every cycle are supported.
- Reset mid-pipeline: in-flight PHVs are discarded; no phv_valid_out is produced for them.

Optional Feature:
- Macro: PHV_INSERT_COND_EN.
- Defined: writes are applied only if val_in[4-STAGE]==1. If that bit is 0, the PHV passes unmodified and is not counted as a mismatch.
- Undefined: condition bits are ignored; enabled slots always write.

Decomposition:
- Shared package rmt_phv_pkg holds:
  - container widths 16/32/48;
  - container counts;
  - PHV/VAL length constants;
  - container base-offset constants;
  - vlan_id bit range;
  - entry nibble field positions.
- One sub-module, ins_off_ram (16x24, read-first, sync read), so a vendor BRAM can be swapped in later.

Test Plan:
- Entry[2]=24'h8000_00 (6B A -> cont 0); PHV with vlan_id=12'h020, 6B A=48'hAABBCCDDEEFF -> 2 cycles later cont_6B[0]=AABBCCDDEEFF, all other bits equal input.
- Entry[3]=24'hC9_0000 (6B A -> idx4, 6B B -> idx1) plus 4B/2B slots enabled, vlan 12'h030 -> each target container replaced; entry 24'hCC_0000 (A and B both idx4) -> cont_6B[4]=B value.
- Table entry 0 untouched (all-zero); 10 back-to-back PHVs with vlan_id[7:4]=0 -> outputs identical to inputs, phv_valid_out pulses match input pattern delayed 2.
- phv_valid_in without val_valid_in 3 times, val_valid_in alone 2 times -> mismatch_cnt=5, unmodified PHVs forwarded; 70000 mismatches -> 16'hFFFF.
- Config write to addr 5 in the same cycle as a PHV with vlan_id[7:4]=5 -> old entry applied; next PHV uses the new entry.
- PHV_INSERT_COND_EN with STAGE=2: val_in[2]=0 -> PHV unmodified, mismatch_cnt unchanged; val_in[2]=1 -> inserted. Assert rst_n mid-stream -> phv_valid_out=0 next cycle, no stale output after release.
